// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// - Register word offsets (addr[3:2])
// - STATUS bit positions
// - Serializer FSM state encoding
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered storage.
// Ports:
//   clk, rst_n     clock, asynchronous active-high reset
//   push, din      write request and data
//   pop, dout      read request; dout shows the head entry combinationally
//   full, empty    occupancy flags
//   count          number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // When full, the popped slot is the one being written; the head value is
  // read before the edge, so overwriting it on the same edge is safe.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Ports:
//   clk, rst_n       clock, asynchronous active-high reset
//   addr, wdata      bus byte address and write data
//   wenable          per-byte write strobes (0 = read / no write)
//   rdata            combinational read data, 0 when not selected
//   hit              address falls inside this block's 16-byte window
//   tx               serial output, idle high
//   irq              registered level interrupt: irq_en & empty & idle
// Registers (addr[3:2]): TXDATA(W) STATUS(R/W1C) CLKDIV(R/W) CTRL(R/W).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  import uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    idx;
  logic          wr_txdata, wr_status, wr_clkdiv0, wr_clkdiv1, wr_ctrl;
  logic          overrun, irq_en;
  logic [15:0]   clkdiv;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [1:0]    state, next_state;
  logic [15:0]   baud_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          bit_end;
  logic          busy;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:16], wenable[3:2]};

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign idx        = addr[3:2];
  assign wr_txdata  = hit && (idx == REG_TXDATA) && wenable[0];
  assign wr_status  = hit && (idx == REG_STATUS) && wenable[0];
  assign wr_clkdiv0 = hit && (idx == REG_CLKDIV) && wenable[0];
  assign wr_clkdiv1 = hit && (idx == REG_CLKDIV) && wenable[1];
  assign wr_ctrl    = hit && (idx == REG_CTRL)   && wenable[0];

  // FIFO handshake: push is a one-edge request from the bus, pop a one-edge
  // request from the serializer; each takes effect on the posedge it is high.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overrun <= 1'b0;
      irq_en  <= 1'b0;
      clkdiv  <= DEFAULT_DIV;
      irq     <= 1'b0;
    end else begin
      if (wr_status && wdata[ST_OVERRUN]) overrun <= 1'b0;
      // A same-edge pop frees a slot, so only an unaided push to a full FIFO drops.
      if (wr_txdata && fifo_full && !fifo_pop) overrun <= 1'b1;
      if (wr_clkdiv0) clkdiv[7:0]  <= wdata[7:0];
      if (wr_clkdiv1) clkdiv[15:8] <= wdata[15:8];
      if (wr_ctrl)    irq_en       <= wdata[0];
      irq <= irq_en && fifo_empty && !busy;
    end
  end

  assign bit_end = (baud_cnt == 16'd0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!fifo_empty) next_state = START;
      START: if (bit_end) next_state = DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) next_state = STOP;
      STOP:  if (bit_end) next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tx       = 1'b1;
    fifo_pop = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:  fifo_pop = !fifo_empty;
      START: tx = 1'b0;
      DATA:  tx = shift[0];
      STOP:  fifo_pop = bit_end && !fifo_empty;
      default: tx = 1'b1;
    endcase
  end

  // Bit timing and shifter. The reload reads clkdiv live, so a divider
  // change lands at the next bit boundary.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
    end else if (fifo_pop) begin
      baud_cnt <= clkdiv;
      shift    <= fifo_dout;
      bit_idx  <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baud_cnt <= clkdiv;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (idx)
        REG_STATUS: begin
          rdata[ST_FULL]             = fifo_full;
          rdata[ST_EMPTY]            = fifo_empty;
          rdata[ST_BUSY]             = busy;
          rdata[ST_OVERRUN]          = overrun;
          rdata[ST_COUNT_LSB +: CW]  = fifo_count;
        end
        REG_CLKDIV: rdata[15:0] = clkdiv;
        REG_CTRL:   rdata[0]    = irq_en;
        default:    rdata       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_CLKDIV = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .wenable (wenable),
    .rdata   (rdata),
    .hit     (hit),
    .tx      (tx),
    .irq     (irq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // drivers: called 1ns after a posedge, return 1ns after the next one
  task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; wenable = be;
    @(posedge clk); #1;
    wenable = 4'b0000;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a; wenable = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    logic [31:0] d;
    read_reg(a, d);
    check(tag, d, exp_v);
  endtask

  // Starts in the first cycle of a start bit; checks every cycle of the frame
  // and ends in the first cycle after the stop bit.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int period);
    logic [9:0] f;
    int mism;
    f = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      mism = 0;
      for (int c = 0; c < period; c++) begin
        if (tx !== f[b]) mism++;
        @(posedge clk); #1;
      end
      check($sformatf("%s bit%0d bad cycles", tag, b), mism, 0);
    end
  endtask

  // Mid-bit sampling receiver for a 101-cycle bit period.
  task automatic rx_byte(output logic [7:0] d, output bit got);
    int t;
    got = 0; d = '0; t = 0;
    while (tx !== 1'b0 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (tx !== 1'b0) return;
    repeat (50) @(posedge clk);
    #1;
    check("rx start bit", {31'b0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (101) @(posedge clk);
      #1;
      d[i] = tx;
    end
    repeat (101) @(posedge clk);
    #1;
    check("rx stop bit", {31'b0, tx}, 32'd1);
    got = 1;
  endtask

  initial begin
    logic [7:0] d;
    bit got;
    int n_frames;
    int lows;

    rst_n = 1'b1; addr = A_STATUS; wdata = '0; wenable = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("tx in reset", {31'b0, tx}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // reset state
    check_reg("reset STATUS", A_STATUS, 32'h0000_0002);
    check_reg("reset CLKDIV", A_CLKDIV, 32'h0000_000F);
    check_reg("reset CTRL", A_CTRL, 32'h0000_0000);
    check("reset tx", {31'b0, tx}, 32'd1);
    check("reset irq", {31'b0, irq}, 32'd0);

    // single frame, CLKDIV=3
    write_reg(A_CLKDIV, 32'd3, 4'b0011);
    write_reg(A_TXDATA, 32'h0000_00A5, 4'b0001);
    check("tx idle at write edge", {31'b0, tx}, 32'd1);
    @(posedge clk); #1;
    check_reg("STATUS first cycle A5", A_STATUS, 32'h0000_0006);
    expect_frame("A5", 8'hA5, 4);
    check_reg("STATUS after A5", A_STATUS, 32'h0000_0002);
    check("tx after A5", {31'b0, tx}, 32'd1);

    // back-to-back frames, CLKDIV=0
    write_reg(A_CLKDIV, 32'd0, 4'b0011);
    write_reg(A_TXDATA, 32'h55, 4'b0001);
    write_reg(A_TXDATA, 32'h0F, 4'b0001);
    check_reg("STATUS count=1 in frame", A_STATUS, 32'h0000_0104);
    expect_frame("55", 8'h55, 1);
    expect_frame("0F", 8'h0F, 1);
    check_reg("STATUS after 55/0F", A_STATUS, 32'h0000_0002);

    // overrun, CLKDIV=100; upper halfword of wdata must not land anywhere
    write_reg(A_CLKDIV, 32'hFFFF_0064, 4'b0011);
    check_reg("CLKDIV=100 readback", A_CLKDIV, 32'h0000_0064);
    for (int i = 0; i < 10; i++) write_reg(A_TXDATA, 32'h10 + i, 4'b0001);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
    check_reg("STATUS full+overrun", A_STATUS, 32'h0000_080D);
    write_reg(A_STATUS, 32'h0000_0008, 4'b0001);
    check_reg("STATUS overrun cleared", A_STATUS, 32'h0000_0805);
    n_frames = 0;
    for (int k = 0; k < 10; k++) begin
      rx_byte(d, got);
      if (got) begin
        n_frames++;
        if (exp_q.size() == 0) check("rx unexpected frame", {24'b0, d}, 32'hFFFF_FFFF);
        else check($sformatf("rx byte %0d", k), {24'b0, d}, {24'b0, exp_q.pop_front()});
      end
    end
    check("frame count", n_frames, 9);
    check_reg("STATUS after overrun run", A_STATUS, 32'h0000_0002);

    // interrupt
    write_reg(A_CLKDIV, 32'd0, 4'b0011);
    write_reg(A_CTRL, 32'd1, 4'b0001);
    check("irq lags enable", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq raised", {31'b0, irq}, 32'd1);
    write_reg(A_TXDATA, 32'h3C, 4'b0001);
    check("irq held at write edge", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq dropped", {31'b0, irq}, 32'd0);
    expect_frame("3C", 8'h3C, 1);
    check("irq low first idle cycle", {31'b0, irq}, 32'd0);
    check_reg("STATUS after 3C", A_STATUS, 32'h0000_0002);
    @(posedge clk); #1;
    check("irq after frame", {31'b0, irq}, 32'd1);
    write_reg(A_CTRL, 32'd0, 4'b0001);
    @(posedge clk); #1;
    check("irq off after disable", {31'b0, irq}, 32'd0);

    // reset mid DATA bit with a byte still queued
    write_reg(A_CLKDIV, 32'd3, 4'b0011);
    write_reg(A_TXDATA, 32'h00, 4'b0001);
    write_reg(A_TXDATA, 32'h00, 4'b0001);
    repeat (5) @(posedge clk);
    #1;
    check("tx data bit before reset", {31'b0, tx}, 32'd0);
    check_reg("STATUS before reset", A_STATUS, 32'h0000_0104);
    rst_n = 1'b1;
    #1;
    check("tx high on async reset", {31'b0, tx}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_reg("STATUS after reset", A_STATUS, 32'h0000_0002);
    check_reg("CLKDIV after reset", A_CLKDIV, 32'h0000_000F);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    check("no residual frame", lows, 0);

    // out-of-window accesses
    addr = BASE + 32'h10; wdata = 32'hFF; wenable = 4'b1111;
    #1;
    check("hit outside window", {31'b0, hit}, 32'd0);
    check("rdata outside window", rdata, 32'd0);
    @(posedge clk); #1;
    wenable = 4'b0000;
    check_reg("rdata alias of STATUS", BASE + 32'h14, 32'd0);
    check_reg("STATUS after stray write", A_STATUS, 32'h0000_0002);
    check("hit inside window", {31'b0, hit}, 32'd1);
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    check("tx idle after stray write", lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data bus (addr / wdata / wenable / rdata), alongside simple_ram.
- The CPU writes bytes into a TX FIFO. An 8N1 serializer drains the FIFO onto `tx` at a programmable bit period.
- The block gives firmware a console and gives benches an observable serial output.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; bits [3:0] must be 0.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd15, reset value of CLKDIV.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high.
- addr  input  32  data bus byte address.
- wdata  input  32  data bus write data.
- wenable  input  4  per-byte write strobes; 4'b0000 = read/no write.
- rdata  output  32  combinational read data; 0 when `hit`=0.
- hit  output  1  addr[31:4] == BASE_ADDR[31:4]; used by the top-level rdata mux.
- tx  output  1  serial line, idle high.
- irq  output  1  level interrupt.

Behaviour:
Register map, index = addr[3:2]:
- 0x0 TXDATA (W): a write with hit=1 and wenable[0]=1 pushes wdata[7:0]. Reads return 0.
- 0x4 STATUS (R/W1C):
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overrun (sticky).
  - bits[15:8] FIFO count, zero-extended.
  - A write with wenable[0]=1 and wdata[3]=1 clears overrun.
- 0x8 CLKDIV (R/W): 16 bits. wenable[0] writes [7:0], wenable[1] writes [15:8]. Upper bytes read 0.
- 0xC CTRL (R/W): bit0 irq_en, written via wenable[0].

Bus rules:
- All register and FIFO updates happen on posedge clk. Reads have no side effects.
- Writes with hit=0 are ignored.
- Push while full (and no pop on the same edge): the data is dropped and overrun is set.
- Push and pop on the same edge: both take effect and count is unchanged. This also holds when full, in which case the push is accepted and overrun is not set.

Reset (rst_n=1, asynchronous):
- tx=1, irq=0, FSM=IDLE, FIFO empty, count=0.
- overrun=0, irq_en=0, CLKDIV=DEFAULT_DIV.
- Reset mid-frame aborts the frame immediately and drives tx high.

Serializer FSM: IDLE, START, DATA, STOP.
- IDLE: tx=1. If the FIFO is non-empty at a posedge: pop into shift reg, load baud counter with CLKDIV, go to START.
- Baud counter: counts down. At 0 the current bit ends and the counter reloads with the current CLKDIV. Each bit therefore lasts CLKDIV+1 cycles.
- A CLKDIV change mid-frame takes effect from the next bit.
- START: tx=0 for one bit period, then DATA with bit index 0.
- DATA: tx=shift[0]; 8 bits, LSB first; shift right at each bit end. After bit 7, go to STOP.
- STOP: tx=1 for one bit period. At its end:
  - FIFO non-empty: pop and go directly to START (back-to-back frames, no gap).
  - Otherwise: go to IDLE.

Timing and derived signals:
- Latency: a TXDATA write at edge N with an idle, empty block gives tx falling after edge N+1.
- Frame length is 10*(CLKDIV+1) cycles.
- busy = (state != IDLE).
- irq = irq_en & empty & ~busy, registered, so it is one cycle behind the condition.

Decomposition:
- Package uart_tx_pkg:
  - register offsets (REG_TXDATA=2'd0, REG_STATUS=2'd1, REG_CLKDIV=2'd2, REG_CTRL=2'd3);
  - STATUS bit positions;
  - FSM state encoding (2-bit localparams IDLE/START/DATA/STOP).
- One sub-module: sync_fifo.
  - Parameters WIDTH=8, DEPTH=FIFO_DEPTH.
  - Ports: push/pop/din/dout/full/empty/count.
  - Registered storage, wrap-around pointers with an extra bit, same-edge push+pop supported.

Test Plan:
- Reset, then read STATUS → rdata=32'h0000_0002, CLKDIV reads 32'h0000_000F, tx=1, irq=0.
- CLKDIV=3, write TXDATA=0xA5 at edge N → tx low from N+1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. busy drops 40 cycles after N+1.
- CLKDIV=0, write 0x55 then 0x0F on consecutive cycles → two 10-cycle frames with no idle gap. STATUS count reads 1 during the first frame.
- CLKDIV=100, write 10 bytes back-to-back → count saturates at 8 and STATUS bit3=1. Writing STATUS=32'h8 clears it. Exactly 9 frames are sent (1 popped immediately + 8 queued; 1 dropped).
- CTRL=1, send one byte → irq rises one cycle after busy falls with FIFO empty. A new TXDATA write drops irq on the following cycle.
- Assert rst_n=1 mid DATA bit → tx=1 immediately. After release: IDLE, empty, CLKDIV=15, no residual frame.
- Write 0xFF to addr BASE_ADDR+0x10 → hit=0, no FIFO change, rdata=0.
